// File: rtl/bus_sequencer.sv
// Hardwired control-step sequencer for the shared 32-bit bus datapath: fetch, then one
// ALU reg/reg, reg/imm or mul/div execute, with Moore-decoded bus enables and load strobes.
module bus_sequencer #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] ir,
  output logic [23:0] out_sel,
  output logic [15:0] reg_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        pc_in,
  output logic        ir_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        y_in,
  output logic        z_in,
  output logic        inc_pc,
  output logic        read,
  output logic [4:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
  } state_t;

  localparam int unsigned SEL_HI   = 16;
  localparam int unsigned SEL_LO   = 17;
  localparam int unsigned SEL_ZHI  = 18;
  localparam int unsigned SEL_ZLOW = 19;
  localparam int unsigned SEL_PC   = 20;
  localparam int unsigned SEL_MDR  = 21;
  localparam int unsigned SEL_C    = 23;

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        t1_first;
  logic [3:0]  ra_q;
  logic [3:0]  rc_q;
  logic        imm_q;
  logic        muldiv_q;
  logic [4:0]  alu_q;

  logic        dec_legal;
  logic        dec_imm;
  logic        dec_muldiv;
  logic [4:0]  dec_alu;

  always_comb begin
    dec_legal  = 1'b1;
    dec_imm    = 1'b0;
    dec_muldiv = 1'b0;
    dec_alu    = '0;
    unique case (ir[31:27])
      5'b00011, 5'b00100, 5'b00101,
      5'b00110, 5'b00111, 5'b01000: dec_alu = ir[31:27];
      5'b01100: begin dec_imm = 1'b1; dec_alu = 5'b00011; end
      5'b01101: begin dec_imm = 1'b1; dec_alu = 5'b00101; end
      5'b01110: begin dec_imm = 1'b1; dec_alu = 5'b00110; end
      5'b01111: begin dec_muldiv = 1'b1; dec_alu = 5'b01111; end
      5'b10000: begin dec_muldiv = 1'b1; dec_alu = 5'b10000; end
      default:  dec_legal = 1'b0;
    endcase
  end

  // ir is only valid from T3, so the decoded fields are captured on leaving T3
  // and T4..T6 run from the captured copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      t1_first <= 1'b0;
      illegal  <= 1'b0;
      ra_q     <= '0;
      rc_q     <= '0;
      imm_q    <= 1'b0;
      muldiv_q <= 1'b0;
      alu_q    <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          state   <= S_T0;
          illegal <= 1'b0;
        end
        S_T0: begin
          state    <= S_T1;
          wait_cnt <= WAIT_LOAD;
          t1_first <= 1'b1;
        end
        S_T1: begin
          t1_first <= 1'b0;
          if (wait_cnt == '0) state <= S_T2;
          else                wait_cnt <= wait_cnt - 4'd1;
        end
        S_T2: state <= S_T3;
        S_T3: begin
          if (!dec_legal) begin
            illegal <= 1'b1;
            state   <= S_DONE;
          end else begin
            ra_q     <= ir[26:23];
            rc_q     <= ir[18:15];
            imm_q    <= dec_imm;
            muldiv_q <= dec_muldiv;
            alu_q    <= dec_alu;
            state    <= S_T4;
          end
        end
        S_T4:   state <= S_T5;
        S_T5:   state <= muldiv_q ? S_T6 : S_DONE;
        S_T6:   state <= S_DONE;
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_sel = '0;
    reg_in  = '0;
    hi_in   = 1'b0;
    lo_in   = 1'b0;
    pc_in   = 1'b0;
    ir_in   = 1'b0;
    mar_in  = 1'b0;
    mdr_in  = 1'b0;
    y_in    = 1'b0;
    z_in    = 1'b0;
    inc_pc  = 1'b0;
    read    = 1'b0;
    alu_op  = '0;
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    unique case (state)
      S_T0: begin
        out_sel[SEL_PC] = 1'b1;
        mar_in          = 1'b1;
        inc_pc          = 1'b1;
        z_in            = 1'b1;
      end
      S_T1: begin
        out_sel[SEL_ZLOW] = 1'b1;
        pc_in             = t1_first;
        read              = 1'b1;
        mdr_in            = 1'b1;
      end
      S_T2: begin
        out_sel[SEL_MDR] = 1'b1;
        ir_in            = 1'b1;
      end
      S_T3: if (dec_legal) begin
        out_sel[ir[22:19]] = 1'b1;
        y_in               = 1'b1;
      end
      S_T4: begin
        if (imm_q) out_sel[SEL_C] = 1'b1;
        else       out_sel[rc_q]  = 1'b1;
        alu_op = alu_q;
        z_in   = 1'b1;
      end
      S_T5: begin
        out_sel[SEL_ZLOW] = 1'b1;
        if (muldiv_q) lo_in        = 1'b1;
        else          reg_in[ra_q] = 1'b1;
      end
      S_T6: begin
        out_sel[SEL_ZHI] = 1'b1;
        hi_in            = 1'b1;
      end
      default: ;
    endcase
  end

  // HI/LO bus sources exist for other control flows; this sequencer never drives them.
  logic unused_sel;
  assign unused_sel = (SEL_HI == SEL_LO);

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: per-cycle output traces derived from the control-step rules,
// compared against two instances (MEM_WAIT=1 and MEM_WAIT=3).
module tb_bus_sequencer;

  typedef struct packed {
    logic [23:0] out_sel;
    logic [15:0] reg_in;
    logic hi_in, lo_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, inc_pc, read;
    logic [4:0]  alu_op;
    logic busy, done, illegal;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [31:0] ir = '0;

  logic [23:0] a_out_sel, b_out_sel;
  logic [15:0] a_reg_in, b_reg_in;
  logic a_hi_in, a_lo_in, a_pc_in, a_ir_in, a_mar_in, a_mdr_in, a_y_in, a_z_in, a_inc_pc, a_read;
  logic b_hi_in, b_lo_in, b_pc_in, b_ir_in, b_mar_in, b_mdr_in, b_y_in, b_z_in, b_inc_pc, b_read;
  logic [4:0] a_alu_op, b_alu_op;
  logic a_busy, a_done, a_illegal, b_busy, b_done, b_illegal;
  obs_t obs_a, obs_b;

  int errors = 0;
  int checks = 0;

  obs_t exp_q[$];
  bit   exp_legal;

  // op, alu_op and operand kind (0 reg/reg, 1 reg/imm, 2 mul/div)
  logic [4:0] op_tab   [11] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                                5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b10000};
  logic [4:0] alu_tab  [11] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                                5'b00011, 5'b00101, 5'b00110, 5'b01111, 5'b10000};
  int         kind_tab [11] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 2};

  always #5 clk = ~clk;

  bus_sequencer #(.MEM_WAIT(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .ir(ir),
    .out_sel(a_out_sel), .reg_in(a_reg_in), .hi_in(a_hi_in), .lo_in(a_lo_in),
    .pc_in(a_pc_in), .ir_in(a_ir_in), .mar_in(a_mar_in), .mdr_in(a_mdr_in),
    .y_in(a_y_in), .z_in(a_z_in), .inc_pc(a_inc_pc), .read(a_read),
    .alu_op(a_alu_op), .busy(a_busy), .done(a_done), .illegal(a_illegal)
  );

  bus_sequencer #(.MEM_WAIT(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .ir(ir),
    .out_sel(b_out_sel), .reg_in(b_reg_in), .hi_in(b_hi_in), .lo_in(b_lo_in),
    .pc_in(b_pc_in), .ir_in(b_ir_in), .mar_in(b_mar_in), .mdr_in(b_mdr_in),
    .y_in(b_y_in), .z_in(b_z_in), .inc_pc(b_inc_pc), .read(b_read),
    .alu_op(b_alu_op), .busy(b_busy), .done(b_done), .illegal(b_illegal)
  );

  assign obs_a = {a_out_sel, a_reg_in, a_hi_in, a_lo_in, a_pc_in, a_ir_in, a_mar_in, a_mdr_in,
                  a_y_in, a_z_in, a_inc_pc, a_read, a_alu_op, a_busy, a_done, a_illegal};
  assign obs_b = {b_out_sel, b_reg_in, b_hi_in, b_lo_in, b_pc_in, b_ir_in, b_mar_in, b_mdr_in,
                  b_y_in, b_z_in, b_inc_pc, b_read, b_alu_op, b_busy, b_done, b_illegal};

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'(($urandom))};
  endfunction

  // Expected outputs for cycles 1..N after start, N being the done cycle.
  task automatic build(input logic [31:0] instr, input int unsigned mw);
    obs_t e;
    int kind = -1;
    logic [4:0] alu = '0;
    for (int i = 0; i < 11; i++)
      if (op_tab[i] == instr[31:27]) begin kind = kind_tab[i]; alu = alu_tab[i]; end
    exp_q.delete();
    exp_legal = (kind >= 0);
    e = '0; e.busy = 1; e.out_sel[20] = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1;
    exp_q.push_back(e);
    for (int unsigned i = 0; i < mw; i++) begin
      e = '0; e.busy = 1; e.out_sel[19] = 1; e.read = 1; e.mdr_in = 1; e.pc_in = (i == 0);
      exp_q.push_back(e);
    end
    e = '0; e.busy = 1; e.out_sel[21] = 1; e.ir_in = 1;
    exp_q.push_back(e);
    if (kind < 0) begin
      e = '0; e.busy = 1;
      exp_q.push_back(e);
    end else begin
      e = '0; e.busy = 1; e.out_sel[instr[22:19]] = 1; e.y_in = 1;
      exp_q.push_back(e);
      e = '0; e.busy = 1; e.alu_op = alu; e.z_in = 1;
      if (kind == 1) e.out_sel[23] = 1; else e.out_sel[instr[18:15]] = 1;
      exp_q.push_back(e);
      e = '0; e.busy = 1; e.out_sel[19] = 1;
      if (kind == 2) e.lo_in = 1; else e.reg_in[instr[26:23]] = 1;
      exp_q.push_back(e);
      if (kind == 2) begin
        e = '0; e.busy = 1; e.out_sel[18] = 1; e.hi_in = 1;
        exp_q.push_back(e);
      end
    end
    e = '0; e.busy = 1; e.done = 1; e.illegal = (kind < 0);
    exp_q.push_back(e);
  endtask

  // start_mode: 0 start low after cycle 0, 1 random start mid-run, 2 start held high
  task automatic run_instr(input bit slow, input logic [31:0] instr, input int start_mode,
                           input string name);
    obs_t got, idle;
    int unsigned mw = slow ? 3 : 1;
    int t3 = 3 + int'(mw);
    build(instr, mw);
    @(posedge clk); #1;
    ir = instr;
    if (slow) start_b = 1; else start_a = 1;
    @(posedge clk); #1;
    for (int c = 1; c <= exp_q.size(); c++) begin
      ir = (c < t3) ? $urandom : instr;
      begin
        logic s;
        s = (start_mode == 2) ? 1'b1 : (start_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (slow) start_b = s; else start_a = s;
      end
      @(negedge clk);
      got = slow ? obs_b : obs_a;
      checks++;
      if (got !== exp_q[c-1]) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, exp_q[c-1]);
      end
      @(posedge clk); #1;
    end
    start_a = 0; start_b = 0;
    @(negedge clk);
    idle = '0; idle.illegal = !exp_legal;
    got = slow ? obs_b : obs_a;
    checks++;
    if (got !== idle) begin
      errors++;
      $display("FAIL %s idle-after: got %h expected %h", name, got, idle);
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    checks++;
    if (obs_a !== obs_t'('0)) begin errors++; $display("FAIL reset_a: got %h expected 0", obs_a); end
    checks++;
    if (obs_b !== obs_t'('0)) begin errors++; $display("FAIL reset_b: got %h expected 0", obs_b); end
  endtask

  task automatic test_add;
    run_instr(0, mk_ir(5'b00011, 4'd3, 4'd1, 4'd2), 0, "add_r3_r1_r2");
  endtask

  task automatic test_addi;
    run_instr(0, mk_ir(5'b01100, 4'd5, 4'd4, 4'd9), 0, "addi_r5_r4");
  endtask

  task automatic test_mul_div;
    run_instr(0, mk_ir(5'b01111, 4'd7, 4'd2, 4'd6), 0, "mul");
    run_instr(0, mk_ir(5'b10000, 4'd0, 4'd15, 4'd0), 0, "div");
  endtask

  task automatic test_illegal;
    run_instr(0, mk_ir(5'b11111, 4'd3, 4'd1, 4'd2), 0, "illegal_op");
    run_instr(0, mk_ir(5'b00110, 4'd0, 4'd14, 4'd13), 0, "or_after_illegal");
    run_instr(0, mk_ir(5'b00000, 4'd1, 4'd1, 4'd1), 0, "illegal_op0");
  endtask

  task automatic test_mid_reset;
    logic [31:0] instr;
    // illegal is still set from the last instruction; a reset in IDLE must clear it
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    checks++;
    if (obs_a !== obs_t'('0)) begin errors++; $display("FAIL reset_idle: got %h expected 0", obs_a); end
    instr = mk_ir(5'b00011, 4'd3, 4'd1, 4'd2);
    build(instr, 1);
    @(posedge clk); #1 ir = instr; start_a = 1;
    @(posedge clk); #1 start_a = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) reset = 1;
      @(negedge clk);
      checks++;
      if (obs_a !== exp_q[c-1]) begin
        errors++;
        $display("FAIL mid_reset cycle %0d: got %h expected %h", c, obs_a, exp_q[c-1]);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      if (k == 1) reset = 0;
      @(negedge clk);
      checks++;
      if (obs_a !== obs_t'('0)) begin
        errors++;
        $display("FAIL mid_reset after %0d: got %h expected 0", k, obs_a);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait;
    run_instr(1, mk_ir(5'b00011, 4'd3, 4'd1, 4'd2), 2, "memwait3_add_start_held");
    run_instr(1, mk_ir(5'b01111, 4'd1, 4'd2, 4'd3), 0, "memwait3_mul");
    run_instr(1, mk_ir(5'b11110, 4'd1, 4'd2, 4'd3), 0, "memwait3_illegal");
  endtask

  task automatic test_back_to_back;
    run_instr(0, mk_ir(5'b01000, 4'd15, 4'd0, 4'd15), 2, "shl_start_held");
    run_instr(0, mk_ir(5'b01101, 4'd0, 4'd0, 4'd0), 2, "andi_r0");
  endtask

  task automatic test_random;
    for (int n = 0; n < 30; n++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 4) == 0) ? 5'($urandom) : op_tab[$urandom_range(0, 10)];
      run_instr(1'($urandom_range(0, 1)), mk_ir(op, 4'($urandom), 4'($urandom), 4'($urandom)),
                1, $sformatf("random_%0d_op%05b", n, op));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_addi();
    test_mul_div();
    test_illegal();
    test_mid_reset();
    test_mem_wait();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
